// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for id_stage_pipe: opcode encodings, funct field
// position, the control bundle and the opcode-to-control table.
package id_stage_pipe_pkg;

   localparam int unsigned OPCODE_W  = 6;
   localparam int unsigned FUNCT_LSB = 0;
   localparam int unsigned FUNCT_W   = 6;

   typedef enum logic [OPCODE_W-1:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   typedef struct packed {
      logic reg_dest;
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic reg_write;
      logic mem_to_reg;
   } ctrl_t;

   localparam int unsigned CTRL_W = $bits(ctrl_t);

   // Unknown opcodes and J produce an all-zero control bundle.
   function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_dest  = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: c.branch = 1'b1;
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Opcodes whose rt field is a source operand (relevant for load-use).
   function automatic logic reads_rt(input logic [OPCODE_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bus bundle between IF/ID, WB, EX and the id_stage_pipe decode stage.
// ID_PERF_COUNTERS_EN adds the stall/bubble counter outputs.
interface id_stage_pipe_if #(
   parameter int NB_INST   = 32,
   parameter int NB_PC     = 32,
   parameter int NB_DATA   = 32,
   parameter int NB_REG    = 5,
   parameter int NB_OPCODE = 6
) ();

   logic                 i_ID_enable;
   logic                 i_ID_valid;
   logic [NB_INST-1:0]   i_ID_inst;
   logic [NB_PC-1:0]     i_ID_pc;
   logic                 i_ID_wb_write;
   logic [NB_REG-1:0]    i_ID_wb_reg;
   logic [NB_DATA-1:0]   i_ID_wb_data;
   logic                 i_ID_ex_mem_read;
   logic [NB_REG-1:0]    i_ID_ex_rt;
   logic                 i_ID_flush;

   logic                 o_ID_stall;
   logic                 o_ID_jump;
   logic [NB_PC-1:0]     o_ID_jump_address;
   logic                 o_ID_valid;
   logic                 o_ID_reg_dest;
   logic                 o_ID_alu_src;
   logic                 o_ID_mem_read;
   logic                 o_ID_mem_write;
   logic                 o_ID_branch;
   logic                 o_ID_reg_write;
   logic                 o_ID_mem_to_reg;
   logic [NB_OPCODE-1:0] o_ID_alu_op;
   logic [NB_DATA-1:0]   o_ID_data_a;
   logic [NB_DATA-1:0]   o_ID_data_b;
   logic [NB_DATA-1:0]   o_ID_immediate;
   logic [NB_REG-1:0]    o_ID_rs;
   logic [NB_REG-1:0]    o_ID_rt;
   logic [NB_REG-1:0]    o_ID_rd;
   logic [NB_PC-1:0]     o_ID_pc;

`ifdef ID_PERF_COUNTERS_EN
   logic [NB_DATA-1:0]   o_ID_stall_count;
   logic [NB_DATA-1:0]   o_ID_bubble_count;

   modport master (
      output i_ID_enable, i_ID_valid, i_ID_inst, i_ID_pc, i_ID_wb_write, i_ID_wb_reg,
             i_ID_wb_data, i_ID_ex_mem_read, i_ID_ex_rt, i_ID_flush,
      input  o_ID_stall, o_ID_jump, o_ID_jump_address, o_ID_valid, o_ID_reg_dest,
             o_ID_alu_src, o_ID_mem_read, o_ID_mem_write, o_ID_branch, o_ID_reg_write,
             o_ID_mem_to_reg, o_ID_alu_op, o_ID_data_a, o_ID_data_b, o_ID_immediate,
             o_ID_rs, o_ID_rt, o_ID_rd, o_ID_pc, o_ID_stall_count, o_ID_bubble_count
   );

   modport slave (
      input  i_ID_enable, i_ID_valid, i_ID_inst, i_ID_pc, i_ID_wb_write, i_ID_wb_reg,
             i_ID_wb_data, i_ID_ex_mem_read, i_ID_ex_rt, i_ID_flush,
      output o_ID_stall, o_ID_jump, o_ID_jump_address, o_ID_valid, o_ID_reg_dest,
             o_ID_alu_src, o_ID_mem_read, o_ID_mem_write, o_ID_branch, o_ID_reg_write,
             o_ID_mem_to_reg, o_ID_alu_op, o_ID_data_a, o_ID_data_b, o_ID_immediate,
             o_ID_rs, o_ID_rt, o_ID_rd, o_ID_pc, o_ID_stall_count, o_ID_bubble_count
   );
`else
   modport master (
      output i_ID_enable, i_ID_valid, i_ID_inst, i_ID_pc, i_ID_wb_write, i_ID_wb_reg,
             i_ID_wb_data, i_ID_ex_mem_read, i_ID_ex_rt, i_ID_flush,
      input  o_ID_stall, o_ID_jump, o_ID_jump_address, o_ID_valid, o_ID_reg_dest,
             o_ID_alu_src, o_ID_mem_read, o_ID_mem_write, o_ID_branch, o_ID_reg_write,
             o_ID_mem_to_reg, o_ID_alu_op, o_ID_data_a, o_ID_data_b, o_ID_immediate,
             o_ID_rs, o_ID_rt, o_ID_rd, o_ID_pc
   );

   modport slave (
      input  i_ID_enable, i_ID_valid, i_ID_inst, i_ID_pc, i_ID_wb_write, i_ID_wb_reg,
             i_ID_wb_data, i_ID_ex_mem_read, i_ID_ex_rt, i_ID_flush,
      output o_ID_stall, o_ID_jump, o_ID_jump_address, o_ID_valid, o_ID_reg_dest,
             o_ID_alu_src, o_ID_mem_read, o_ID_mem_write, o_ID_branch, o_ID_reg_write,
             o_ID_mem_to_reg, o_ID_alu_op, o_ID_data_a, o_ID_data_b, o_ID_immediate,
             o_ID_rs, o_ID_rt, o_ID_rd, o_ID_pc
   );
`endif

endinterface

// File: rtl/id_stage_pipe_reg_file_bypass.sv
// Register file for the decode stage: two combinational read ports, one
// write port, reg 0 and unimplemented registers read as zero, and a
// write-through bypass so a same-cycle WB write is visible to the reader.
module reg_file_bypass #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               wb_write,
   input  logic [NB_REG-1:0]  wb_reg,
   input  logic [NB_DATA-1:0] wb_data,
   input  logic [NB_REG-1:0]  addr_a,
   input  logic [NB_REG-1:0]  addr_b,
   output logic [NB_DATA-1:0] data_a,
   output logic [NB_DATA-1:0] data_b
);

   localparam int unsigned DEPTH = 2 ** NB_REG;

   // One bit per address: set only for implemented, writable registers, so
   // reg 0 and addresses >= N_REGS share a single "reads as zero" rule.
   function automatic logic [DEPTH-1:0] present_mask();
      logic [DEPTH-1:0] m;
      m = '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (i < N_REGS) m[i] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [DEPTH-1:0] PRESENT = present_mask();

   logic [NB_DATA-1:0] mem [DEPTH];

   // Register array: cleared on reset, written only on enabled edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (enable && wb_write && PRESENT[wb_reg]) begin
         mem[wb_reg] <= wb_data;
      end
   end

   // Read ports with write-through bypass.
   always_comb begin
      data_a = '0;
      data_b = '0;
      if (PRESENT[addr_a]) data_a = (wb_write && (wb_reg == addr_a)) ? wb_data : mem[addr_a];
      if (PRESENT[addr_b]) data_b = (wb_write && (wb_reg == addr_b)) ? wb_data : mem[addr_b];
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with integrated ID/EX register, load-use stall, flush bubble
// and jump redirect. ID_PERF_COUNTERS_EN adds saturating stall/bubble counters.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int NB_INST   = 32,
   parameter int NB_PC     = 32,
   parameter int NB_DATA   = 32,
   parameter int NB_REG    = 5,
   parameter int N_REGS    = 32,
   parameter int NB_OPCODE = 6
) (
   input  logic            i_ID_clock,
   input  logic            i_ID_reset,
   id_stage_pipe_if.slave  bus
);

   typedef struct packed {
      logic                 valid;
      ctrl_t                ctrl;
      logic [NB_OPCODE-1:0] alu_op;
      logic [NB_DATA-1:0]   data_a;
      logic [NB_DATA-1:0]   data_b;
      logic [NB_DATA-1:0]   imm;
      logic [NB_REG-1:0]    rs;
      logic [NB_REG-1:0]    rt;
      logic [NB_REG-1:0]    rd;
      logic [NB_PC-1:0]     pc;
   } idex_t;

   logic [OPCODE_W-1:0] opcode;
   logic [NB_REG-1:0]   rs;
   logic [NB_REG-1:0]   rt;
   logic [NB_REG-1:0]   rd;
   logic [NB_DATA-1:0]  rf_a;
   logic [NB_DATA-1:0]  rf_b;
   logic                hazard;
   logic                stall;
   logic                bubble;
   idex_t               idex_d;
   idex_t               idex_q;

   assign opcode = bus.i_ID_inst[NB_INST-1 -: OPCODE_W];
   assign rs     = NB_REG'(bus.i_ID_inst[25:21]);
   assign rt     = NB_REG'(bus.i_ID_inst[20:16]);
   assign rd     = NB_REG'(bus.i_ID_inst[15:11]);

   reg_file_bypass #(
      .NB_DATA (NB_DATA),
      .NB_REG  (NB_REG),
      .N_REGS  (N_REGS)
   ) u_rf (
      .clk      (i_ID_clock),
      .rst      (i_ID_reset),
      .enable   (bus.i_ID_enable),
      .wb_write (bus.i_ID_wb_write),
      .wb_reg   (bus.i_ID_wb_reg),
      .wb_data  (bus.i_ID_wb_data),
      .addr_a   (rs),
      .addr_b   (rt),
      .data_a   (rf_a),
      .data_b   (rf_b)
   );

   assign hazard = bus.i_ID_valid && bus.i_ID_ex_mem_read && (bus.i_ID_ex_rt != '0) &&
                   ((bus.i_ID_ex_rt == rs) || ((bus.i_ID_ex_rt == rt) && reads_rt(opcode)));

   // Stall and jump are suppressed while frozen or in reset so IF never acts
   // on a cycle that this stage does not advance.
   assign stall  = hazard && !bus.i_ID_flush && bus.i_ID_enable && !i_ID_reset;
   assign bubble = stall || bus.i_ID_flush || !bus.i_ID_valid;

   assign bus.o_ID_stall        = stall;
   assign bus.o_ID_jump         = bus.i_ID_valid && (opcode == OP_J) && !stall &&
                                  !bus.i_ID_flush && bus.i_ID_enable && !i_ID_reset;
   assign bus.o_ID_jump_address = NB_PC'({bus.i_ID_pc[NB_PC-1 -: 4], bus.i_ID_inst[25:0], 2'b00});

   // Decoded next-state of the ID/EX register when the instruction is accepted.
   always_comb begin
      idex_d        = '0;
      idex_d.valid  = bus.i_ID_valid;
      idex_d.ctrl   = bus.i_ID_valid ? decode_ctrl(opcode) : '0;
      idex_d.alu_op = NB_OPCODE'(opcode);
      idex_d.data_a = rf_a;
      idex_d.data_b = rf_b;
      idex_d.imm    = NB_DATA'($signed(bus.i_ID_inst[15:0]));
      idex_d.rs     = rs;
      idex_d.rt     = rt;
      idex_d.rd     = rd;
      idex_d.pc     = bus.i_ID_pc;
   end

   // ID/EX register: reset, then hold when disabled, then bubble on flush or
   // hazard, else capture the decode.
   always_ff @(posedge i_ID_clock) begin
      if (i_ID_reset) begin
         idex_q <= '0;
      end else if (bus.i_ID_enable) begin
         if (bus.i_ID_flush || hazard) idex_q <= '0;
         else                          idex_q <= idex_d;
      end
   end

   assign bus.o_ID_valid      = idex_q.valid;
   assign bus.o_ID_reg_dest   = idex_q.ctrl.reg_dest;
   assign bus.o_ID_alu_src    = idex_q.ctrl.alu_src;
   assign bus.o_ID_mem_read   = idex_q.ctrl.mem_read;
   assign bus.o_ID_mem_write  = idex_q.ctrl.mem_write;
   assign bus.o_ID_branch     = idex_q.ctrl.branch;
   assign bus.o_ID_reg_write  = idex_q.ctrl.reg_write;
   assign bus.o_ID_mem_to_reg = idex_q.ctrl.mem_to_reg;
   assign bus.o_ID_alu_op     = idex_q.alu_op;
   assign bus.o_ID_data_a     = idex_q.data_a;
   assign bus.o_ID_data_b     = idex_q.data_b;
   assign bus.o_ID_immediate  = idex_q.imm;
   assign bus.o_ID_rs         = idex_q.rs;
   assign bus.o_ID_rt         = idex_q.rt;
   assign bus.o_ID_rd         = idex_q.rd;
   assign bus.o_ID_pc         = idex_q.pc;

`ifdef ID_PERF_COUNTERS_EN
   logic [NB_DATA-1:0] stall_count;
   logic [NB_DATA-1:0] bubble_count;

   // Saturating stall and bubble counters, frozen while disabled.
   always_ff @(posedge i_ID_clock) begin
      if (i_ID_reset) begin
         stall_count  <= '0;
         bubble_count <= '0;
      end else if (bus.i_ID_enable) begin
         if (stall && (stall_count != '1))    stall_count  <= stall_count + 1'b1;
         if (bubble && (bubble_count != '1))  bubble_count <= bubble_count + 1'b1;
      end
   end

   assign bus.o_ID_stall_count  = stall_count;
   assign bus.o_ID_bubble_count = bubble_count;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe. Expected ID/EX contents come from a
// reference model with its own register file and are queued on the drive
// side, then popped and compared after the clock edge.
module tb_id_stage_pipe;

   typedef struct packed {
      logic        valid;
      logic [6:0]  ctrl;
      logic [5:0]  alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   id_stage_pipe_if #(
      .NB_INST   (32),
      .NB_PC     (32),
      .NB_DATA   (32),
      .NB_REG    (5),
      .NB_OPCODE (6)
   ) bus ();

   id_stage_pipe #(
      .NB_INST   (32),
      .NB_PC     (32),
      .NB_DATA   (32),
      .NB_REG    (5),
      .N_REGS    (32),
      .NB_OPCODE (6)
   ) dut (
      .i_ID_clock (clk),
      .i_ID_reset (rst),
      .bus        (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] rf [32];
   exp_t        cur;
   exp_t        sb [$];
`ifdef ID_PERF_COUNTERS_EN
   logic [31:0] m_stall_cnt;
   logic [31:0] m_bubble_cnt;
`endif

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'h00:        return 7'b1000010;
         6'h23:        return 7'b0110011;
         6'h2b:        return 7'b0101000;
         6'h04, 6'h05: return 7'b0000100;
         6'h08:        return 7'b0100010;
         default:      return 7'b0000000;
      endcase
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] addr, input logic wbw,
                                            input logic [4:0] wbr, input logic [31:0] wbd);
      if (addr == 5'd0) return 32'd0;
      if (wbw && (wbr == addr)) return wbd;
      return rf[addr];
   endfunction

   // One clock of stimulus: drive, check combinational outputs, predict and
   // queue the ID/EX state, clock, then pop and compare.
   task automatic drive(input logic r, input logic en, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic wbw, input logic [4:0] wbr,
                        input logic [31:0] wbd, input logic exm, input logic [4:0] ext,
                        input logic fl);
      logic [5:0] op;
      logic [4:0] s, t, d;
      logic       haz, e_stall, e_jump, uses_t;
      exp_t       nxt, got;

      rst                  = r;
      bus.i_ID_enable      = en;
      bus.i_ID_valid       = v;
      bus.i_ID_inst        = inst;
      bus.i_ID_pc          = pc;
      bus.i_ID_wb_write    = wbw;
      bus.i_ID_wb_reg      = wbr;
      bus.i_ID_wb_data     = wbd;
      bus.i_ID_ex_mem_read = exm;
      bus.i_ID_ex_rt       = ext;
      bus.i_ID_flush       = fl;
      #2;

      op = inst[31:26];
      s  = inst[25:21];
      t  = inst[20:16];
      d  = inst[15:11];
      uses_t  = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
      haz     = v && exm && (ext != 5'd0) && ((ext == s) || ((ext == t) && uses_t));
      e_stall = !r && en && haz && !fl;
      e_jump  = !r && en && v && (op == 6'h02) && !e_stall && !fl;
      check("stall", {63'd0, bus.o_ID_stall}, {63'd0, e_stall});
      check("jump", {63'd0, bus.o_ID_jump}, {63'd0, e_jump});
      if (e_jump) check("jump_addr", {32'd0, bus.o_ID_jump_address}, {32'd0, pc[31:28], inst[25:0], 2'b00});

      if (r)               nxt = '0;
      else if (!en)        nxt = cur;
      else if (fl || haz)  nxt = '0;
      else begin
         nxt.valid  = v;
         nxt.ctrl   = v ? ref_ctrl(op) : 7'd0;
         nxt.alu_op = op;
         nxt.a      = ref_read(s, wbw, wbr, wbd);
         nxt.b      = ref_read(t, wbw, wbr, wbd);
         nxt.imm    = {{16{inst[15]}}, inst[15:0]};
         nxt.rs     = s;
         nxt.rt     = t;
         nxt.rd     = d;
         nxt.pc     = pc;
      end
      sb.push_back(nxt);

`ifdef ID_PERF_COUNTERS_EN
      if (r) begin
         m_stall_cnt  = 32'd0;
         m_bubble_cnt = 32'd0;
      end else if (en) begin
         if (e_stall && (m_stall_cnt != 32'hFFFF_FFFF)) m_stall_cnt++;
         if ((e_stall || fl || !v) && (m_bubble_cnt != 32'hFFFF_FFFF)) m_bubble_cnt++;
      end
`endif

      @(posedge clk);
      #1;

      if (r) begin
         for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      end else if (en && wbw && (wbr != 5'd0)) begin
         rf[wbr] = wbd;
      end
      cur = nxt;

      got = sb.pop_front();
      check("valid", {63'd0, bus.o_ID_valid}, {63'd0, got.valid});
      check("ctrl", {57'd0, bus.o_ID_reg_dest, bus.o_ID_alu_src, bus.o_ID_mem_read, bus.o_ID_mem_write,
                     bus.o_ID_branch, bus.o_ID_reg_write, bus.o_ID_mem_to_reg}, {57'd0, got.ctrl});
      check("alu_op", {58'd0, bus.o_ID_alu_op}, {58'd0, got.alu_op});
      check("data_a", {32'd0, bus.o_ID_data_a}, {32'd0, got.a});
      check("data_b", {32'd0, bus.o_ID_data_b}, {32'd0, got.b});
      check("imm", {32'd0, bus.o_ID_immediate}, {32'd0, got.imm});
      check("rs", {59'd0, bus.o_ID_rs}, {59'd0, got.rs});
      check("rt", {59'd0, bus.o_ID_rt}, {59'd0, got.rt});
      check("rd", {59'd0, bus.o_ID_rd}, {59'd0, got.rd});
      check("pc", {32'd0, bus.o_ID_pc}, {32'd0, got.pc});
`ifdef ID_PERF_COUNTERS_EN
      check("stall_count", {32'd0, bus.o_ID_stall_count}, {32'd0, m_stall_cnt});
      check("bubble_count", {32'd0, bus.o_ID_bubble_count}, {32'd0, m_bubble_cnt});
`endif
   endtask

   task automatic drive_random(input logic r);
      logic [5:0]  op;
      logic [31:0] inst;
      logic [4:0]  s, t, d;
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
         0:       op = 6'h00;
         1:       op = 6'h23;
         2:       op = 6'h2b;
         3:       op = 6'h04;
         4:       op = 6'h05;
         5:       op = 6'h08;
         6:       op = 6'h02;
         default: op = 6'h3f;
      endcase
      inst = (op == 6'h00) ? mk_r(s, t, d) : mk_i(op, s, t, 16'($urandom));
      drive(r, r ? 1'b1 : ($urandom_range(0, 9) != 0), $urandom_range(0, 5) != 0, inst, $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      cur = '0;
`ifdef ID_PERF_COUNTERS_EN
      m_stall_cnt  = 32'd0;
      m_bubble_cnt = 32'd0;
`endif

      // Reset with random inputs.
      repeat (3) drive_random(1'b1);

      // r5 written, visible, then cleared by reset.
      drive(0, 1, 0, 32'd0, 32'h0, 1, 5'd5, 32'h5555_5555, 0, 5'd0, 0);
      drive(0, 1, 1, mk_r(5'd5, 5'd5, 5'd1), 32'h4, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive_random(1'b1);
      drive(0, 1, 1, mk_r(5'd5, 5'd5, 5'd1), 32'h8, 0, 5'd0, 32'd0, 0, 5'd0, 0);

      // Same-cycle WB bypass on both read ports.
      drive(0, 1, 1, mk_r(5'd3, 5'd3, 5'd1), 32'hC, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 0);

      // Preload r4 and r5; a write to r0 must be ignored.
      drive(0, 1, 0, 32'd0, 32'h0, 1, 5'd4, 32'h4444_4444, 0, 5'd0, 0);
      drive(0, 1, 0, 32'd0, 32'h0, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 0);
      drive(0, 1, 0, 32'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 0);
      drive(0, 1, 1, mk_r(5'd0, 5'd4, 5'd9), 32'h10, 0, 5'd0, 32'd0, 0, 5'd0, 0);

      // Load-use on rs: one stall cycle with a bubble, then the ADD enters.
      drive(0, 1, 1, mk_r(5'd4, 5'd5, 5'd2), 32'h100, 0, 5'd0, 32'd0, 1, 5'd4, 0);
      drive(0, 1, 1, mk_r(5'd4, 5'd5, 5'd2), 32'h100, 0, 5'd0, 32'd0, 0, 5'd0, 0);

      // Hazard together with flush: flush wins.
      drive(0, 1, 1, mk_r(5'd4, 5'd5, 5'd2), 32'h104, 0, 5'd0, 32'd0, 1, 5'd4, 1);

      // rt-only hazards: SW stalls, ADDI does not; ex_rt of 0 and invalid ID never stall.
      drive(0, 1, 1, mk_i(6'h2b, 5'd1, 5'd4, 16'h0010), 32'h108, 0, 5'd0, 32'd0, 1, 5'd4, 0);
      drive(0, 1, 1, mk_i(6'h08, 5'd1, 5'd4, 16'hFFF0), 32'h10C, 0, 5'd0, 32'd0, 1, 5'd4, 0);
      drive(0, 1, 1, mk_r(5'd0, 5'd0, 5'd3), 32'h110, 0, 5'd0, 32'd0, 1, 5'd0, 0);
      drive(0, 1, 0, mk_r(5'd4, 5'd4, 5'd3), 32'h114, 0, 5'd0, 32'd0, 1, 5'd4, 0);

      // Jump redirect, and jump suppressed by flush.
      drive(0, 1, 1, {6'h02, 26'h000_0100}, 32'h4000_0004, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive(0, 1, 1, {6'h02, 26'h000_0100}, 32'h4000_0008, 0, 5'd0, 32'd0, 0, 5'd0, 1);

      // Remaining opcodes, an unknown opcode and an invalid slot.
      drive(0, 1, 1, mk_i(6'h23, 5'd5, 5'd6, 16'h0004), 32'h200, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive(0, 1, 1, mk_i(6'h04, 5'd4, 5'd5, 16'h8000), 32'h204, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive(0, 1, 1, mk_i(6'h05, 5'd5, 5'd4, 16'h7FFF), 32'h208, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive(0, 1, 1, mk_i(6'h3f, 5'd4, 5'd5, 16'h1234), 32'h20C, 0, 5'd0, 32'd0, 0, 5'd0, 0);
      drive(0, 1, 0, mk_r(5'd4, 5'd5, 5'd6), 32'h210, 0, 5'd0, 32'd0, 0, 5'd0, 0);

      // Freeze for three cycles with a WB write and a hazard pending.
      repeat (3) drive(0, 0, 1, mk_r(5'd6, 5'd6, 5'd7), 32'h300, 1, 5'd6, 32'h6666_6666, 1, 5'd6, 0);
      drive(0, 1, 1, mk_r(5'd6, 5'd4, 5'd7), 32'h304, 0, 5'd0, 32'd0, 0, 5'd0, 0);

      // Reset arriving during a stall.
      drive(0, 1, 1, mk_r(5'd4, 5'd5, 5'd2), 32'h400, 0, 5'd0, 32'd0, 1, 5'd4, 0);
      drive(1, 1, 1, mk_r(5'd4, 5'd5, 5'd2), 32'h400, 0, 5'd0, 32'd0, 1, 5'd4, 0);

      // Constrained-random traffic.
      repeat (60) drive_random(1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
